fpl_bus_master: RTL and testbench
=================================

// Module: fpl_bus_master
// PURPOSE
//  Initiator side of the card's paged-window bus. Turns flat 19-bit byte requests into
//  strobed cycles on the shared tri-state data bus. Page bits [18:13] go to the page-latch
//  target (lat_cs); offset [12:0] goes to the 8 KB window target (win_cs).
//  Caches the last page written and inserts a page-latch write only on page change.
// PARAMETERS
//  SETUP_CYC   1      cycles address/cs (and write data) valid before strobe, >=1
//  STROBE_CYC  2      cycles re/we held asserted, >=1
//  HOLD_CYC    1      cycles address/cs/data held after strobe, >=1
//  ID_VALUE    8'h46  expected page-latch ID byte (PAGE_ID_CHECK_EN only)
// PORTS
//  clk         in   1   clock
//  rst         in   1   reset, synchronous, active-high
//  req_valid   in   1   request present
//  req_ready   out  1   request accepted when req_valid&&req_ready at posedge
//  req_write   in   1   1=write, 0=read
//  req_addr    in   19  flat byte address
//  req_wdata   in   8   write data
//  page_inval  in   1   forget cached page; next access rewrites latch
//  rsp_valid   out  1   one-cycle completion pulse, no backpressure
//  rsp_rdata   out  8   read data, valid with rsp_valid (reads only, else held)
//  bus_addr    out  13  window offset
//  bus_d       inout 8  shared data bus
//  lat_cs      out  1   page-latch select
//  win_cs      out  1   window select
//  bus_re      out  1   read strobe
//  bus_we      out  1   write strobe
//  id_ok       out  1   ID check passed
//  id_err      out  1   ID check failed
// BEHAVIOUR
//  Reset: req_ready=0, rsp_valid=0, rsp_rdata=0, bus_addr=0, cs/re/we=0, bus_d=z.
//   Page cache invalid. id_ok=id_err=0.
//  FSM: IDLE -> [PG_SETUP->PG_STROBE->PG_HOLD] -> AC_SETUP->AC_STROBE->AC_HOLD -> RESP -> IDLE.
//   Each phase lasts its *_CYC count via one down-counter.
//  req_ready=1 only in IDLE. A request is captured on accept.
//   Miss (cache invalid or req_addr[18:13]!=cache) enters PG_SETUP; hit enters AC_SETUP.
//  Page cycle: lat_cs=1 through setup/strobe/hold, bus_we=1 in strobe only.
//   bus_d drives {2'b00,page} during all three phases. Cache is loaded with page and
//   marked valid at the end of PG_HOLD.
//  Access cycle: win_cs=1, bus_addr=offset, through setup/strobe/hold.
//   Strobe is bus_we (write) or bus_re (read).
//   Write: bus_d drives wdata in all three phases.
//   Read: bus_d=z throughout; bus_d is registered into rsp_rdata on the posedge ending the
//   last STROBE cycle.
//  RESP: rsp_valid=1 for exactly one cycle, then IDLE (req_ready=1 the following cycle).
//  Latency, accept edge to rsp_valid high: hit = S+T+H+1 cycles; miss = 2*(S+T+H)+1.
//   With defaults: hit 5, miss 9.
//  At most one of lat_cs/win_cs is high; re and we never high together.
//   bus_d is z whenever no write phase is active.
//  page_inval: clears cache valid at the next edge in any state. If asserted in the accept
//   cycle, the accepted request is treated as a miss.
//   Mid-page-cycle: the page cycle completes, but cache stays invalid.
//  Reset mid-operation: all outputs return to reset values at that edge. The in-flight
//   request is dropped with no rsp_valid.
// CONFIGURATION
//  PAGE_ID_CHECK_EN defined: after reset, one read cycle (S/T/H timing) is run on lat_cs
//   before IDLE. Sampled byte==ID_VALUE sets id_ok=1, otherwise id_err=1 (sticky until rst).
//   req_ready stays 0 until the check ends; requests are served regardless of result.
//  Not defined: no check; IDLE is entered the cycle after rst falls.
//   id_ok tied 1, id_err tied 0.
// TESTING
//  1 Reset, then write 0x12345=0xA5: one page write (bus_d=0x09 on lat_cs), then window write
//    bus_addr=0x0345, d=0xA5. rsp_valid 9 cycles after accept.
//  2 Read 0x12000 next, target drives 0x3C: no page cycle, rsp_rdata=0x3C, latency 5.
//  3 Read 0x02000 after 0x12000: page write 0x01, then read; pulse page_inval and repeat
//    0x02000 -> page write reissued.
//  4 Assert rst during AC_STROBE of a write: cs/we low and bus_d=z at next edge, no
//    rsp_valid. Next same-page access rewrites the page.
//  5 PAGE_ID_CHECK_EN, model returns 0x46 -> id_ok=1; returns 0x00 -> id_err=1.
//    req_ready low until the check finishes in both cases.
//  6 Back-to-back requests with req_valid held high: req_ready low while busy, each request
//    gets exactly one rsp_valid. A monitor checks bus_d is never driven during a read.

Source files
------------

// File: rtl/fpl_bus_master.sv
// Paged-window bus initiator: caches the last page and writes the page latch only on a page change.
// Latency from accept to rsp_valid: hit SETUP+STROBE+HOLD+1 cycles; miss 2*(SETUP+STROBE+HOLD)+1.
// req_ready is high only in IDLE; rsp_valid is a single-cycle pulse that cannot be stalled.
// Optional feature macro: PAGE_ID_CHECK_EN (reads the page-latch ID byte once after reset).
module fpl_bus_master #(
    parameter int unsigned SETUP_CYC  = 1,
    parameter int unsigned STROBE_CYC = 2,
    parameter int unsigned HOLD_CYC   = 1,
    parameter logic [7:0]  ID_VALUE   = 8'h46
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [18:0] req_addr,
    input  logic [7:0]  req_wdata,
    input  logic        page_inval,
    output logic        rsp_valid,
    output logic [7:0]  rsp_rdata,
    output logic [12:0] bus_addr,
    inout  wire  [7:0]  bus_d,
    output logic        lat_cs,
    output logic        win_cs,
    output logic        bus_re,
    output logic        bus_we,
    output logic        id_ok,
    output logic        id_err
);

    // Phase counters are loaded with CYC-1 and the phase ends when they reach zero.
    localparam logic [7:0] C_S = 8'(SETUP_CYC - 1);
    localparam logic [7:0] C_T = 8'(STROBE_CYC - 1);
    localparam logic [7:0] C_H = 8'(HOLD_CYC - 1);

    typedef enum logic [3:0] {
        ST_RST, ST_ID_SETUP, ST_ID_STROBE, ST_ID_HOLD, ST_IDLE,
        ST_PG_SETUP, ST_PG_STROBE, ST_PG_HOLD,
        ST_AC_SETUP, ST_AC_STROBE, ST_AC_HOLD, ST_RESP
    } state_t;

    state_t      r_state, w_state_nxt;
    logic [7:0]  r_cnt, w_cnt_nxt;
    logic [18:0] r_addr;
    logic        r_write;
    logic [7:0]  r_wdata;
    logic [7:0]  r_rdata;
    logic [5:0]  r_pg;
    logic        r_pg_vld;
    logic        r_pg_inval;
    logic        w_done, w_miss, w_in_pg;
    logic        w_accept, w_pg_done, w_rd_sample;
    logic        w_oe;
    logic [7:0]  w_dout;

    assign w_done  = (r_cnt == 8'd0);
    assign w_miss  = !r_pg_vld || page_inval || (req_addr[18:13] != r_pg);
    assign w_in_pg = (r_state == ST_PG_SETUP) || (r_state == ST_PG_STROBE) || (r_state == ST_PG_HOLD);

    assign bus_d     = w_oe ? w_dout : 8'hzz;
    assign bus_addr  = r_addr[12:0];
    assign rsp_rdata = r_rdata;

    // State register and phase down-counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_RST;
            r_cnt   <= 8'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state and bus decode; every output is a pure function of the current phase.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = (r_cnt != 8'd0) ? r_cnt - 8'd1 : 8'd0;
        w_accept    = 1'b0;
        w_pg_done   = 1'b0;
        w_rd_sample = 1'b0;
        w_oe        = 1'b0;
        w_dout      = 8'h00;
        req_ready   = 1'b0;
        rsp_valid   = 1'b0;
        lat_cs      = 1'b0;
        win_cs      = 1'b0;
        bus_re      = 1'b0;
        bus_we      = 1'b0;
        case (r_state)
            ST_RST: begin
`ifdef PAGE_ID_CHECK_EN
                w_state_nxt = ST_ID_SETUP;
                w_cnt_nxt   = C_S;
`else
                w_state_nxt = ST_IDLE;
`endif
            end
            ST_ID_SETUP: begin
                lat_cs = 1'b1;
                if (w_done) begin w_state_nxt = ST_ID_STROBE; w_cnt_nxt = C_T; end
            end
            ST_ID_STROBE: begin
                lat_cs = 1'b1;
                bus_re = 1'b1;
                if (w_done) begin w_state_nxt = ST_ID_HOLD; w_cnt_nxt = C_H; end
            end
            ST_ID_HOLD: begin
                lat_cs = 1'b1;
                if (w_done) w_state_nxt = ST_IDLE;
            end
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = w_miss ? ST_PG_SETUP : ST_AC_SETUP;
                    w_cnt_nxt   = C_S;
                end
            end
            ST_PG_SETUP: begin
                lat_cs = 1'b1;
                w_oe   = 1'b1;
                w_dout = {2'b00, r_addr[18:13]};
                if (w_done) begin w_state_nxt = ST_PG_STROBE; w_cnt_nxt = C_T; end
            end
            ST_PG_STROBE: begin
                lat_cs = 1'b1;
                bus_we = 1'b1;
                w_oe   = 1'b1;
                w_dout = {2'b00, r_addr[18:13]};
                if (w_done) begin w_state_nxt = ST_PG_HOLD; w_cnt_nxt = C_H; end
            end
            ST_PG_HOLD: begin
                lat_cs = 1'b1;
                w_oe   = 1'b1;
                w_dout = {2'b00, r_addr[18:13]};
                if (w_done) begin
                    w_pg_done   = 1'b1;
                    w_state_nxt = ST_AC_SETUP;
                    w_cnt_nxt   = C_S;
                end
            end
            ST_AC_SETUP: begin
                win_cs = 1'b1;
                w_oe   = r_write;
                w_dout = r_wdata;
                if (w_done) begin w_state_nxt = ST_AC_STROBE; w_cnt_nxt = C_T; end
            end
            ST_AC_STROBE: begin
                win_cs = 1'b1;
                bus_we = r_write;
                bus_re = !r_write;
                w_oe   = r_write;
                w_dout = r_wdata;
                if (w_done) begin
                    w_rd_sample = !r_write;
                    w_state_nxt = ST_AC_HOLD;
                    w_cnt_nxt   = C_H;
                end
            end
            ST_AC_HOLD: begin
                win_cs = 1'b1;
                w_oe   = r_write;
                w_dout = r_wdata;
                if (w_done) w_state_nxt = ST_RESP;
            end
            ST_RESP: begin
                rsp_valid   = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Request capture on accept and read-data capture at the end of the last strobe cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr  <= 19'd0;
            r_write <= 1'b0;
            r_wdata <= 8'h00;
            r_rdata <= 8'h00;
        end else begin
            if (w_accept) begin
                r_addr  <= req_addr;
                r_write <= req_write;
                r_wdata <= req_wdata;
            end
            if (w_rd_sample) r_rdata <= bus_d;
        end
    end

    // Page cache: an invalidate seen during a page cycle keeps that page from being marked valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pg       <= 6'd0;
            r_pg_vld   <= 1'b0;
            r_pg_inval <= 1'b0;
        end else begin
            if (page_inval) begin
                r_pg_vld <= 1'b0;
            end else if (w_pg_done && !r_pg_inval) begin
                r_pg_vld <= 1'b1;
                r_pg     <= r_addr[18:13];
            end
            if (w_pg_done)                 r_pg_inval <= 1'b0;
            else if (page_inval && w_in_pg) r_pg_inval <= 1'b1;
        end
    end

`ifdef PAGE_ID_CHECK_EN
    logic r_id_ok, r_id_err;

    // Sticky ID result, sampled at the end of the ID read strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_id_ok  <= 1'b0;
            r_id_err <= 1'b0;
        end else if (r_state == ST_ID_STROBE && w_done) begin
            if (bus_d == ID_VALUE) r_id_ok  <= 1'b1;
            else                   r_id_err <= 1'b1;
        end
    end

    assign id_ok  = r_id_ok;
    assign id_err = r_id_err;
`else
    logic w_unused_id;
    assign w_unused_id = ^ID_VALUE;
    assign id_ok       = 1'b1;
    assign id_err      = 1'b0;
`endif

endmodule

// File: tb/tb_fpl_bus_master.sv
module tb_fpl_bus_master;

    localparam int S = 1;
    localparam int T = 2;
    localparam int H = 1;
    localparam int N = S + T + H;
    localparam logic [7:0] IDV = 8'h46;
`ifdef PAGE_ID_CHECK_EN
    localparam int RDY_WAIT = N + 1;
`else
    localparam int RDY_WAIT = 1;
`endif

    logic        clk, rst, req_valid, req_write, page_inval;
    logic [18:0] req_addr;
    logic [7:0]  req_wdata;
    wire         req_ready, rsp_valid, lat_cs, win_cs, bus_re, bus_we, id_ok, id_err;
    wire  [7:0]  rsp_rdata;
    wire  [12:0] bus_addr;
    wire  [7:0]  bus_d;

    // Bench side of the shared bus: target data during read windows, keeper value otherwise.
    logic        tb_drv;
    logic [7:0]  tb_val;
    assign bus_d = tb_drv ? tb_val : 8'hzz;

    int total;
    int bad;

    // Reference model: cached page and last read byte.
    bit         m_cv;
    logic [5:0] m_cp;
    logic [7:0] m_rdata;
    logic [5:0] pg_tab [4];

    fpl_bus_master #(.SETUP_CYC(S), .STROBE_CYC(T), .HOLD_CYC(H), .ID_VALUE(IDV)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .page_inval(page_inval), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .bus_addr(bus_addr), .bus_d(bus_d), .lat_cs(lat_cs), .win_cs(win_cs),
        .bus_re(bus_re), .bus_we(bus_we), .id_ok(id_ok), .id_err(id_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Release reset and wait (bounded) for the master to become ready.
    task automatic finish_reset(input logic [7:0] idb);
        int waited;
        waited = 0;
        tb_drv = 1'b1;
        tb_val = idb;
        rst    = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #2;
            if (req_ready === 1'b1) begin waited = c; break; end
        end
        chk("ready_wait_after_reset", waited, RDY_WAIT);
        chk("rsp_valid_after_reset", rsp_valid, 0);
`ifdef PAGE_ID_CHECK_EN
        chk("id_ok", id_ok, (idb == IDV) ? 1 : 0);
        chk("id_err", id_err, (idb == IDV) ? 0 : 1);
`else
        chk("id_ok", id_ok, 1);
        chk("id_err", id_err, 0);
`endif
        tb_val  = 8'h00;
        m_cv    = 1'b0;
        m_rdata = 8'h00;
    endtask

    task automatic do_reset(input logic [7:0] idb);
        rst = 1'b1; req_valid = 1'b0; page_inval = 1'b0;
        tb_drv = 1'b1; tb_val = idb;
        repeat (2) @(posedge clk);
        #2;
        chk("rst_req_ready", req_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        chk("rst_bus_addr", bus_addr, 0);
        chk("rst_cs", {lat_cs, win_cs}, 0);
        chk("rst_re_we", {bus_re, bus_we}, 0);
        chk("rst_bus_d_released", bus_d, idb);
        finish_reset(idb);
    endtask

    // One request, checked cycle by cycle against phase windows derived from S/T/H.
    // rst_k != 0 asserts reset at the sample point of cycle rst_k after accept.
    task automatic do_req(input bit w, input logic [18:0] a, input logic [7:0] wd,
                          input logic [7:0] rd, input bit inv_acc, input bit inv_mid,
                          input bit keep, input int rst_k);
        bit miss, aborted;
        int base, last, j;
        logic [5:0] pg;
        bit e_lat, e_win, e_re, e_we, e_oe, e_tgt, e_rsp, e_rdy;
        logic [7:0] e_dout;
        pg = a[18:13];
        aborted = 1'b0;
        req_write = w; req_addr = a; req_wdata = wd; req_valid = 1'b1; page_inval = inv_acc;
        chk("ready_before_accept", req_ready, 1);
        miss = !m_cv || (m_cp != pg) || inv_acc;
        base = miss ? N : 0;
        last = base + N + 1;
        for (int k = 1; k <= last + 1; k++) begin
            @(posedge clk); #1;
            if (k == 1) req_valid = keep;
            page_inval = inv_mid && (k == 2);
            if (rst_k != 0 && k == rst_k + 1) begin
                tb_drv = 1'b1; tb_val = 8'h00;
                #1;
                chk("midrst_cs", {lat_cs, win_cs}, 0);
                chk("midrst_re_we", {bus_re, bus_we}, 0);
                chk("midrst_bus_d_released", bus_d, 8'h00);
                chk("midrst_rsp_valid", rsp_valid, 0);
                chk("midrst_req_ready", req_ready, 0);
                chk("midrst_rsp_rdata", rsp_rdata, 0);
                finish_reset(IDV);
                aborted = 1'b1;
                break;
            end
            {e_lat, e_win, e_re, e_we, e_oe, e_tgt, e_rsp, e_rdy} = '0;
            e_dout = 8'h00;
            if (miss && k <= N) begin
                e_lat  = 1'b1;
                e_we   = (k > S) && (k <= S + T);
                e_oe   = 1'b1;
                e_dout = {2'b00, pg};
            end else if (k <= base + N) begin
                j      = k - base;
                e_win  = 1'b1;
                if (j > S && j <= S + T) begin e_we = w; e_re = !w; end
                e_oe   = w;
                e_dout = wd;
                e_tgt  = !w;
            end else if (k == last) begin
                e_rsp = 1'b1;
            end else begin
                e_rdy = 1'b1;
            end
            tb_drv = !e_oe;
            tb_val = e_tgt ? rd : 8'h00;
            #1;
            chk($sformatf("req_ready@%0d", k), req_ready, e_rdy);
            chk($sformatf("rsp_valid@%0d", k), rsp_valid, e_rsp);
            chk($sformatf("lat_cs@%0d", k), lat_cs, e_lat);
            chk($sformatf("win_cs@%0d", k), win_cs, e_win);
            chk($sformatf("bus_re@%0d", k), bus_re, e_re);
            chk($sformatf("bus_we@%0d", k), bus_we, e_we);
            chk($sformatf("bus_d@%0d", k), bus_d, e_oe ? e_dout : tb_val);
            if (e_win) chk($sformatf("bus_addr@%0d", k), bus_addr, a[12:0]);
            if (e_rsp) chk("rsp_rdata", rsp_rdata, w ? m_rdata : rd);
            if (k == rst_k) begin rst = 1'b1; req_valid = 1'b0; end
        end
        if (!aborted) begin
            if (miss) begin m_cv = 1'b1; m_cp = pg; end
            if (inv_mid) m_cv = 1'b0;
            if (!w) m_rdata = rd;
        end
    endtask

    initial begin
        clk = 1'b0; rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; page_inval = 1'b0;
        req_addr = '0; req_wdata = '0; tb_drv = 1'b1; tb_val = 8'h00;
        total = 0; bad = 0; m_cv = 1'b0; m_cp = '0; m_rdata = '0;
        pg_tab = '{6'h01, 6'h02, 6'h09, 6'h3F};

        do_reset(IDV);

        // Write to a new page, then hit read in the same page.
        do_req(1'b1, 19'h12345, 8'hA5, 8'h00, 1'b0, 1'b0, 1'b0, 0);
        do_req(1'b0, 19'h12000, 8'h00, 8'h3C, 1'b0, 1'b0, 1'b0, 0);

        // Page change, then explicit invalidate while idle forces the latch write again.
        do_req(1'b0, 19'h02000, 8'h00, 8'h5A, 1'b0, 1'b0, 1'b0, 0);
        page_inval = 1'b1;
        @(posedge clk); #2;
        page_inval = 1'b0;
        m_cv = 1'b0;
        chk("ready_after_inval", req_ready, 1);
        do_req(1'b0, 19'h02000, 8'h00, 8'hC3, 1'b0, 1'b0, 1'b0, 0);

        // Invalidate during the page cycle: the following same-page access misses again.
        do_req(1'b1, 19'h04ABC, 8'h11, 8'h00, 1'b0, 1'b1, 1'b0, 0);
        do_req(1'b0, 19'h04000, 8'h00, 8'h81, 1'b0, 1'b0, 1'b0, 0);
        do_req(1'b0, 19'h04001, 8'h00, 8'h7E, 1'b0, 1'b0, 1'b0, 0);
        // Invalidate in the accept cycle turns a would-be hit into a miss.
        do_req(1'b0, 19'h04002, 8'h00, 8'h99, 1'b1, 1'b0, 1'b0, 0);

        // Reset in the middle of a write strobe, then the same page must be rewritten.
        do_req(1'b1, 19'h04010, 8'h77, 8'h00, 1'b0, 1'b0, 1'b0, S + 1);
        do_req(1'b1, 19'h04010, 8'h78, 8'h00, 1'b0, 1'b0, 1'b0, 0);

        // Back-to-back with req_valid held high.
        for (int i = 0; i < 6; i++) begin
            do_req(i[0], {pg_tab[i % 4], 13'(i * 97)}, 8'(8'h20 + i), 8'(8'hB0 + i),
                   1'b0, 1'b0, 1'b1, 0);
        end

        // Randomized mix of pages, directions, invalidates and held valid.
        for (int i = 0; i < 40; i++) begin
            do_req(($urandom_range(0, 1) == 1),
                   {pg_tab[$urandom_range(0, 3)], 13'($urandom_range(0, 8191))},
                   8'($urandom_range(1, 255)), 8'($urandom_range(0, 255)),
                   ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
                   ($urandom_range(0, 1) == 1), 0);
        end
        req_valid = 1'b0;

`ifdef PAGE_ID_CHECK_EN
        // Wrong ID byte: error flag set, requests still served.
        do_reset(8'h00);
        do_req(1'b0, 19'h12000, 8'h00, 8'h42, 1'b0, 1'b0, 1'b0, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
